// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, device-clocked shift-out and ack check.
// Drives the open-drain kclk/kdata pair through active-high output enables.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       kclk_i,
  input  logic       kdata_i,
  output logic       kclk_oe,
  output logic       kdata_oe
);

  localparam int MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] INHIBIT_PRE  = CW'(INHIBIT_CYCLES - 2);
  localparam logic [CW-1:0] INHIBIT_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, SHIFT, ACK, WAITIDLE, DONE, ERR} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [9:0]    shift;
  logic [3:0]    bit_cnt;
  logic          kclk_s1, kclk_s2, kclk_prev;
  logic          kdata_s1, kdata_s2;
  logic          fall;
  logic          timeout;

  // Synchronizers reset to the idle-bus level so reset itself never fakes an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      kclk_s1   <= 1'b1;
      kclk_s2   <= 1'b1;
      kclk_prev <= 1'b1;
      kdata_s1  <= 1'b1;
      kdata_s2  <= 1'b1;
    end else begin
      kclk_s1   <= kclk_i;
      kclk_s2   <= kclk_s1;
      kclk_prev <= kclk_s2;
      kdata_s1  <= kdata_i;
      kdata_s2  <= kdata_s1;
    end
  end

  assign fall    = kclk_prev & ~kclk_s2;
  assign timeout = ~fall && (cnt == TIMEOUT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      shift    <= '0;
      bit_cnt  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      kclk_oe  <= 1'b0;
      kdata_oe <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          kclk_oe  <= 1'b0;
          kdata_oe <= 1'b0;
          if (start) begin
            shift    <= {1'b1, ~^din, din};
            cnt      <= '0;
            bit_cnt  <= '0;
            busy     <= 1'b1;
            kclk_oe  <= 1'b1;
            kdata_oe <= (INHIBIT_CYCLES == 1);
            state    <= INHIBIT;
          end
        end
        // Data is pulled low one cycle before the clock is released (request-to-send).
        INHIBIT: begin
          cnt <= cnt + CW'(1);
          if (cnt == INHIBIT_PRE) kdata_oe <= 1'b1;
          if (cnt == INHIBIT_LAST) begin
            kclk_oe  <= 1'b0;
            kdata_oe <= 1'b1;
            cnt      <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (fall) begin
            cnt      <= '0;
            kdata_oe <= ~shift[0];
            shift    <= {1'b0, shift[9:1]};
            bit_cnt  <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd9) state <= ACK;
          end else if (timeout) begin
            err      <= 1'b1;
            busy     <= 1'b0;
            kclk_oe  <= 1'b0;
            kdata_oe <= 1'b0;
            state    <= ERR;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ACK: begin
          if (fall) begin
            cnt <= '0;
            if (kdata_s2) begin
              err      <= 1'b1;
              busy     <= 1'b0;
              kclk_oe  <= 1'b0;
              kdata_oe <= 1'b0;
              state    <= ERR;
            end else begin
              state <= WAITIDLE;
            end
          end else if (timeout) begin
            err      <= 1'b1;
            busy     <= 1'b0;
            kclk_oe  <= 1'b0;
            kdata_oe <= 1'b0;
            state    <= ERR;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAITIDLE: begin
          if (kclk_s2 && kdata_s2) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else if (fall) begin
            cnt <= '0;
          end else if (timeout) begin
            err      <= 1'b1;
            busy     <= 1'b0;
            kclk_oe  <= 1'b0;
            kdata_oe <= 1'b0;
            state    <= ERR;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: state <= IDLE;
        ERR: begin
          kclk_oe  <= 1'b0;
          kdata_oe <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: an open-drain bus plus a behavioural PS/2 device
// that clocks the frame out, acks or nacks, and a reference model built from the framing rules.
module tb_ps2_host_tx;

  localparam int INHIB = 20;
  localparam int TOUT  = 300;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       start;
  logic       busy, done, err;
  logic       kclk_oe, kdata_oe;
  logic       dev_clk_low, dev_data_low;
  logic       kclk_line, kdata_line;

  assign kclk_line  = ~(kclk_oe | dev_clk_low);
  assign kdata_line = ~(kdata_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INHIB), .TIMEOUT_CYCLES(TOUT)) dut (
    .clk(clk), .rst(rst), .din(din), .start(start),
    .busy(busy), .done(done), .err(err),
    .kclk_i(kclk_line), .kdata_i(kdata_line),
    .kclk_oe(kclk_oe), .kdata_oe(kdata_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  string cur_test = "reset";

  int   done_cnt, err_cnt, both_cnt, busy_gap;
  bit   track, ended;
  logic [2:0]  accept_obs;
  logic [4:0]  rst_obs;
  logic [2:0]  post_lines;
  logic [9:0]  frame;
  logic        start_bit;
  int          inhibit_len, kdata_rise, timeout_len;

  // One clock step; outputs are sampled on the falling edge and pulse bookkeeping is updated.
  task automatic tick();
    @(negedge clk);
    if (track) begin
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (done && err) both_cnt++;
      if (!ended && !busy && !done && !err) busy_gap++;
      if (done || err) ended = 1'b1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s/%s: observed=%0h expected=%0h", cur_test, tag, obs, exp);
    end
  endtask

  // Reference frame as the device sees it: data LSB first, odd parity, stop=1.
  function automatic logic [31:0] expFrame(input logic [7:0] d);
    int ones;
    ones = $countones(d);
    return 32'(d) + ((ones % 2 == 0) ? 32'd256 : 32'd0) + 32'd512;
  endfunction

  // mode 0: device acks, 1: device nacks, 2: device never clocks.
  task automatic applyStimulus(input logic [7:0] d, input int mode, input int rst_after, input bit poke);
    int h, n, rise, m;
    h = $urandom_range(14, 8);
    done_cnt = 0; err_cnt = 0; both_cnt = 0; busy_gap = 0;
    ended = 1'b0; frame = '0; timeout_len = 0; rst_obs = '1;
    din = d;
    start = 1'b1;
    track = 1'b1;
    tick();
    start = 1'b0;
    accept_obs = {busy, kclk_oe, kdata_oe};
    n = 0; rise = 0;
    while (kclk_oe && n < INHIB + 20) begin
      n++;
      if (kdata_oe && rise == 0) rise = n;
      tick();
    end
    inhibit_len = n;
    kdata_rise  = rise;
    start_bit   = kdata_line;
    if (mode == 2) begin
      m = 0;
      while (!err && m < TOUT + 50) begin
        tick();
        m++;
      end
      timeout_len = m;
    end else begin
      for (int k = 1; k <= 10; k++) begin
        repeat (h) tick();
        dev_clk_low = 1'b1;
        if (k == rst_after) begin
          repeat (h) tick();
          rst = 1'b1;
          track = 1'b0;
          tick();
          rst = 1'b0;
          rst_obs = {busy, done, err, kclk_oe, kdata_oe};
          dev_clk_low = 1'b0;
          repeat (5) tick();
          return;
        end
        if (poke && k == 3) begin
          start = 1'b1;
          din = 8'h55;
        end
        tick();
        start = 1'b0;
        repeat (h - 1) tick();
        frame[k-1] = kdata_line;
        dev_clk_low = 1'b0;
      end
      repeat (h / 2) tick();
      if (mode == 0) dev_data_low = 1'b1;
      repeat (h - h / 2) tick();
      dev_clk_low = 1'b1;
      repeat (h) tick();
      dev_clk_low = 1'b0;
      repeat (2) tick();
      dev_data_low = 1'b0;
      m = 0;
      while (!ended && m < TOUT) begin
        tick();
        m++;
      end
    end
    repeat (3) tick();
    post_lines = {kclk_oe, kdata_oe, busy};
    track = 1'b0;
  endtask

  task automatic checkTransfer(input logic [7:0] d, input int mode);
    checkOutput("accept", 32'(accept_obs), 32'b110);
    checkOutput("inhibit_len", inhibit_len, INHIB);
    checkOutput("kdata_rise", kdata_rise, INHIB);
    checkOutput("start_bit", 32'(start_bit), 0);
    if (mode == 2) checkOutput("timeout_len", timeout_len, TOUT);
    else checkOutput("frame", 32'(frame), expFrame(d));
    checkOutput("done_cnt", done_cnt, (mode == 0) ? 1 : 0);
    checkOutput("err_cnt", err_cnt, (mode == 0) ? 0 : 1);
    checkOutput("both_cnt", both_cnt, 0);
    checkOutput("busy_gap", busy_gap, 0);
    checkOutput("ended", 32'(ended), 1);
    checkOutput("post_lines", 32'(post_lines), 0);
  endtask

  initial begin
    logic [7:0] d;
    rst = 1'b1; start = 1'b0; din = 8'h00;
    dev_clk_low = 1'b0; dev_data_low = 1'b0;
    track = 1'b0; ended = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checkOutput("outputs", 32'({busy, done, err, kclk_oe, kdata_oe}), 0);

    cur_test = "ack_ED";
    applyStimulus(8'hED, 0, 0, 1'b0);
    checkTransfer(8'hED, 0);
    cur_test = "ack_01";
    applyStimulus(8'h01, 0, 0, 1'b0);
    checkTransfer(8'h01, 0);
    cur_test = "ack_00";
    applyStimulus(8'h00, 0, 0, 1'b0);
    checkTransfer(8'h00, 0);

    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom);
      cur_test = $sformatf("rand_%0d_%02h", i, d);
      applyStimulus(d, 0, 0, 1'b0);
      checkTransfer(d, 0);
    end

    d = 8'($urandom);
    cur_test = "nack";
    applyStimulus(d, 1, 0, 1'b0);
    checkTransfer(d, 1);

    cur_test = "timeout";
    applyStimulus(8'hFF, 2, 0, 1'b0);
    checkTransfer(8'hFF, 2);

    d = 8'($urandom);
    cur_test = "start_ignored";
    applyStimulus(d, 0, 0, 1'b1);
    checkTransfer(d, 0);

    cur_test = "reset_mid";
    applyStimulus(8'hA3, 0, 5, 1'b0);
    checkOutput("accept", 32'(accept_obs), 32'b110);
    checkOutput("rst_outputs", 32'(rst_obs), 0);
    checkOutput("done_cnt", done_cnt, 0);
    checkOutput("err_cnt", err_cnt, 0);

    d = 8'($urandom);
    cur_test = "after_reset";
    applyStimulus(d, 0, 0, 1'b0);
    checkTransfer(d, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter. It sends command bytes such as 0xED (set LEDs) and 0xFF (reset) to the keyboard over the same open-drain kclk/kdata pair used by the PS/2 receive path. It implements the inhibit, request-to-send, device-clocked shift-out and acknowledge sequence. It reports completion or failure with single-cycle pulses, and asserts `busy` so the receive path can mask the bus while a transmit is in progress.

## Interface
- `INHIBIT_CYCLES`, default 5000: clock-low inhibit time in clk cycles (≥100 µs at the system clock).
- `TIMEOUT_CYCLES`, default 1000000: maximum clk cycles allowed between device clock falling edges, and for the final bus release.
- `clk`  in  1: system clock; all logic on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `din`  in  8: byte to send; sampled when `start` is accepted.
- `start`  in  1: single-cycle request; accepted only while `busy`=0.
- `busy`  out  1: high from the cycle after acceptance until the cycle `done`/`err` pulses.
- `done`  out  1: one-cycle pulse; the device acknowledged the byte.
- `err`  out  1: one-cycle pulse; NACK or timeout.
- `kclk_i`  in  1: PS/2 clock pin level, asynchronous.
- `kdata_i`  in  1: PS/2 data pin level, asynchronous.
- `kclk_oe`  out  1: 1 = drive kclk low; 0 = release the line (pull-up).
- `kdata_oe`  out  1: 1 = drive kdata low; 0 = release the line.

## Operation
- Input conditioning:
  - `kclk_i` and `kdata_i` each pass through a 2-flop synchronizer.
  - A kclk falling edge (`fall`) is a 1-cycle strobe: previous synchronized value 1, current value 0.
- Shift register, 10 bits: `{1'b1, ~^din, din}`. That is din[0] first, then the odd-parity bit, then the stop bit (1 = release).
- States:
  - IDLE: `kclk_oe`=0, `kdata_oe`=0. `start` latches the shift register, clears the counter, and goes to INHIBIT.
  - INHIBIT: `kclk_oe`=1. The counter runs for INHIBIT_CYCLES cycles. `kdata_oe` is set to 1 during the last cycle. Then go to SHIFT.
  - SHIFT: `kclk_oe`=0 and `kdata_oe`=1 (start bit) until the first `fall`.
    - On each `fall`: `kdata_oe` <= ~shift[0], shift right, bit count +1.
    - Falls 1–8 present din[0..7], fall 9 presents parity, fall 10 presents stop (line released).
    - After fall 10, go to ACK.
  - ACK: on the next `fall`, sample synchronized kdata. 0 → WAITIDLE; 1 → ERR (NACK).
  - WAITIDLE: wait until synchronized kclk=1 and kdata=1, then DONE.
  - DONE: pulse `done` for one cycle, then IDLE.
  - ERR: release both lines, pulse `err` for one cycle, then IDLE.
- Timeout:
  - In SHIFT, ACK and WAITIDLE, the counter clears on every `fall`. Otherwise it increments each cycle.
  - Counter reaching TIMEOUT_CYCLES → ERR.
- The counter is a single shared register, sized for the larger of the two parameters.
- `start` while `busy`=1 is ignored, with no queueing; `din` is not re-sampled.
- `start` in the same cycle that `done`/`err` pulses is ignored, because the FSM is not yet in IDLE.
- Reset, including mid-transfer: state IDLE, `kclk_oe`=0, `kdata_oe`=0, `busy`=0, `done`=0, `err`=0, counters cleared. Reset releases the bus in the next cycle.

## Timing
- Acceptance: `start` high in cycle N (IDLE) → `busy`=1 and `kclk_oe`=1 from cycle N+1.
- `kclk_oe` stays high for exactly INHIBIT_CYCLES cycles. `kdata_oe` rises in the final inhibit cycle, so the two overlap for 1 cycle.
- Fall-to-data latency: `kdata_oe` updates 3 clk cycles after the physical kclk falling edge (2-flop synchronizer plus edge register). This is far inside the device's half-period of about 30 µs.
- `done`/`err` are registered. `busy` falls in the same cycle that `done`/`err` pulses.
- `done` and `err` are never asserted together. Exactly one of them pulses per accepted `start`, unless reset intervenes.

## Test plan
- Device model clocks 11 falls at 12.5 kHz, acks with data low; send din=0xED → observed bits 0,1,0,1,1,0,1,1,1, parity 1, stop 1; `done` pulses once; `busy` is high for the whole transfer.
- din=0x01 → parity bit 0. din=0x00 → parity bit 1. Both end with `done`.
- Device leaves kdata high on the 11th fall (NACK) → `err` pulses; `kclk_oe`=`kdata_oe`=0 afterwards.
- Device never clocks after the inhibit → `err` exactly TIMEOUT_CYCLES cycles after the last counter clear; lines released.
- Inhibit check with INHIBIT_CYCLES=20 → `kclk_oe` is high for exactly 20 cycles; `kdata_oe` rises on cycle 20.
- `start` pulsed mid-transfer with din=0x55 → ignored; the original byte completes. `rst` asserted after fall 5 → next cycle all outputs 0 and state IDLE; a subsequent `start` completes normally.
